// File: rtl/guess_eval_core.sv
// guess_eval_core: evaluates a one-hot LED guess against the spinner wheel position.
// Define GUESS_EVAL_SCORE_EN to compile in the saturating 4-bit hit score.
module guess_eval_core (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] pos_i,
  input  logic       running_i,
  input  logic [5:0] guess_i,
  input  logic       score_clr_i,
  output logic       dp_o,
  output logic       hit_o,
  output logic       miss_o,
  output logic       guess_valid_o,
  output logic [3:0] score_o
);

  localparam int unsigned NUM_POS = 6;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned SCORE_W = 4;

  logic       running_q;
  logic       dp_q, dp_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       match_c;
  logic       stop_c;
  logic [7:0] guess_ext_c;

  // Zero-extend so invalid positions 6 and 7 index a 0 bit instead of going out of range.
  assign guess_ext_c   = {2'b00, guess_i};
  assign guess_valid_o = $onehot(guess_i);
  assign match_c       = guess_valid_o && (pos_i <= POS_W'(NUM_POS - 1)) && guess_ext_c[pos_i];
  assign stop_c        = running_q && !running_i;

  always_comb begin
    dp_d   = 1'b0;
    hit_d  = 1'b0;
    miss_d = 1'b0;
    dp_d   = !running_i && match_c;
    if (stop_c) begin
      hit_d  = match_c;
      miss_d = !match_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running_q <= 1'b0;
      dp_q      <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      running_q <= running_i;
      dp_q      <= dp_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign dp_o   = dp_q;
  assign hit_o  = hit_q;
  assign miss_o = miss_q;

`ifdef GUESS_EVAL_SCORE_EN
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [SCORE_W-1:0] score_q, score_d;

  // Count follows the registered hit pulse; clear takes priority.
  always_comb begin
    score_d = score_q;
    if (score_clr_i) begin
      score_d = '0;
    end else if (hit_q && (score_q != SCORE_MAX)) begin
      score_d = score_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;
`else
  logic unused_score_clr;

  assign unused_score_clr = score_clr_i;
  assign score_o          = SCORE_W'(0);
`endif

endmodule

// File: tb/tb_guess_eval_core.sv
// Self-checking bench for guess_eval_core; expected outputs queued per driven cycle.
module tb_guess_eval_core;

  logic       clk;
  logic       rst_n;
  logic [2:0] pos;
  logic       running;
  logic [5:0] guess;
  logic       clr;
  logic       dp, hit, miss, gvalid;
  logic [3:0] score;

  typedef struct {
    logic       dp;
    logic       hit;
    logic       miss;
    logic [3:0] score;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  // Reference state
  logic       run_m;
  logic       hit_m;
  logic [3:0] score_m;

  guess_eval_core dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pos_i        (pos),
    .running_i    (running),
    .guess_i      (guess),
    .score_clr_i  (clr),
    .dp_o         (dp),
    .hit_o        (hit),
    .miss_o       (miss),
    .guess_valid_o(gvalid),
    .score_o      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    run_m   = 1'b0;
    hit_m   = 1'b0;
    score_m = 4'd0;
  endtask

  // Drive one cycle of inputs, queue the expected registered outputs, then compare.
  task automatic step(input logic [2:0] p, input logic r, input logic [5:0] g,
                      input logic c, input string name);
    exp_t e;
    exp_t got;
    int   ones;
    logic v;
    logic m;
    @(negedge clk);
    pos = p; running = r; guess = g; clr = c;
    ones = 0;
    for (int i = 0; i < 6; i++) if (g[i]) ones++;
    v = (ones == 1);
    m = 1'b0;
    for (int i = 0; i < 6; i++) if ((int'(p) == i) && g[i]) m = v;
    #1;
    checks++;
    if (gvalid !== v)
      $display("FAIL %s.guess_valid got=%b exp=%b", name, gvalid, v);
    else
      passed++;
    e.name  = name;
    e.dp    = !r && m;
    e.hit   = run_m && !r && m;
    e.miss  = run_m && !r && !m;
`ifdef GUESS_EVAL_SCORE_EN
    if (c) e.score = 4'd0;
    else if (hit_m && (score_m != 4'd15)) e.score = score_m + 4'd1;
    else e.score = score_m;
`else
    e.score = 4'd0;
`endif
    run_m   = r;
    hit_m   = e.hit;
    score_m = e.score;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checks++;
    if ({dp, hit, miss, score} !== {got.dp, got.hit, got.miss, got.score})
      $display("FAIL %s dp/hit/miss/score got=%b/%b/%b/%0d exp=%b/%b/%b/%0d", got.name,
               dp, hit, miss, score, got.dp, got.hit, got.miss, got.score);
    else
      passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pos = 3'd0; running = 1'b0; guess = 6'b000000; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dp, hit, miss, score} !== 7'b0)
      $display("FAIL reset got=%b/%b/%b/%0d exp=0/0/0/0", dp, hit, miss, score);
    else
      passed++;
    @(negedge clk);
    rst_n = 1'b1;
    // Low running right after reset must not look like a stop event.
    step(3'd4, 1'b0, 6'b010000, 1'b0, "post_reset_low");
  endtask

  task automatic test_spinning_sweep();
    for (int i = 0; i < 6; i++) step(3'(i), 1'b1, 6'b010000, 1'b0, "spin_sweep");
  endtask

  task automatic test_stopped_sweep();
    step(3'd0, 1'b1, 6'b010000, 1'b0, "pre_stop");
    step(3'd0, 1'b0, 6'b010000, 1'b0, "stop_at0");
    for (int i = 1; i < 8; i++) step(3'(i), 1'b0, 6'b010000, 1'b0, "stopped_sweep");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "stopped_at4");
    step(3'd4, 1'b1, 6'b010000, 1'b0, "rise_dp_drop");
  endtask

  task automatic test_hit_miss();
    step(3'd4, 1'b1, 6'b010000, 1'b0, "spin");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "hit_stop");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "hit_hold");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "hit_score");
    step(3'd2, 1'b1, 6'b010000, 1'b0, "spin");
    step(3'd2, 1'b0, 6'b010000, 1'b0, "miss_stop");
    step(3'd2, 1'b0, 6'b010000, 1'b0, "miss_hold");
  endtask

  task automatic test_invalid_guess();
    step(3'd4, 1'b1, 6'b010010, 1'b0, "multi_spin");
    step(3'd4, 1'b0, 6'b010010, 1'b0, "multi_stop");
    step(3'd1, 1'b0, 6'b010010, 1'b0, "multi_pos1");
    step(3'd1, 1'b1, 6'b000000, 1'b0, "zero_spin");
    step(3'd1, 1'b0, 6'b000000, 1'b0, "zero_stop");
  endtask

  task automatic test_back_to_back();
    step(3'd5, 1'b1, 6'b100000, 1'b0, "b2b_spin");
    step(3'd5, 1'b0, 6'b100000, 1'b0, "b2b_hit");
    step(3'd0, 1'b1, 6'b100000, 1'b0, "b2b_spin");
    step(3'd0, 1'b0, 6'b100000, 1'b0, "b2b_miss");
  endtask

  task automatic test_score_saturate();
    for (int i = 0; i < 16; i++) begin
      step(3'd3, 1'b1, 6'b001000, 1'b0, "sat_spin");
      step(3'd3, 1'b0, 6'b001000, 1'b0, "sat_hit");
    end
    step(3'd3, 1'b0, 6'b001000, 1'b0, "sat_settle");
    step(3'd3, 1'b0, 6'b001000, 1'b0, "sat_hold");
    step(3'd3, 1'b1, 6'b001000, 1'b0, "clr_spin");
    step(3'd3, 1'b0, 6'b001000, 1'b0, "clr_hit");
    step(3'd3, 1'b0, 6'b001000, 1'b1, "clr_vs_hit");
    step(3'd3, 1'b0, 6'b001000, 1'b0, "clr_after");
  endtask

  task automatic test_reset_mid();
    step(3'd4, 1'b1, 6'b010000, 1'b0, "rst_spin");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "rst_hit");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "rst_score");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dp, hit, miss, score} !== 7'b0)
      $display("FAIL reset_mid got=%b/%b/%b/%0d exp=0/0/0/0", dp, hit, miss, score);
    else
      passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd4, 1'b0, 6'b010000, 1'b0, "rst_release");
    step(3'd4, 1'b0, 6'b010000, 1'b0, "rst_no_pulse");
  endtask

  initial begin
    test_reset();
    test_spinning_sweep();
    test_stopped_sweep();
    test_hit_miss();
    test_invalid_guess();
    test_back_to_back();
    test_score_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/guess_eval_core.md
# guess_eval_core

Evaluates the player's LED guess against the spinner wheel position in the LED-spinner game. Sits between the spinner position generator and the seven-segment/LED output stage. Drives the decimal-point indicator while the wheel is stopped on the guessed LED. Emits one-cycle hit/miss pulses when a spin ends, and optionally keeps a saturating hit score.

## Interface
Parameters:
- none (six wheel positions fixed; position and guess widths fixed)

Ports:
- clk_i  input  1  system clock; all state updates on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- pos_i  input  3  current wheel position; valid 0..5, 6 and 7 are invalid
- running_i  input  1  1 = wheel spinning, 0 = wheel stopped
- guess_i  input  6  player guess, one-hot; bit n selects position n
- score_clr_i  input  1  synchronous score clear
- dp_o  output  1  decimal-point indicator, registered
- hit_o  output  1  one-cycle pulse: spin ended on the guessed position
- miss_o  output  1  one-cycle pulse: spin ended off the guessed position
- guess_valid_o  output  1  guess_i has exactly one bit set, combinational
- score_o  output  4  saturating hit count

## Operation
- match = guess_valid && (pos_i <= 5) && guess_i[pos_i].
- guess_valid = popcount(guess_i) == 1. A zero or multi-hot guess never matches.
- dp_o next = !running_i && match. dp_o is always 0 while the wheel is spinning.
- running_q register holds the previous running_i.
- Stop event: running_q == 1 && running_i == 0. This is the falling edge of running_i.
- On a stop event, hit_o next = match and miss_o next = !match. Otherwise both next = 0.
- hit_o and miss_o are never high together.
- Score:
  - Increments by 1 on the cycle hit_o is registered high.
  - Saturates at 15.
  - score_clr_i has priority over increment and sets the score to 0.
- pos_i change while stopped: dp_o follows the new pos_i after one cycle. No new hit/miss pulse; pulses occur only on stop events.
- Rising edge of running_i: no event. dp_o drops to 0 on the next cycle.

## Timing
- Reset values: dp_o=0, hit_o=0, miss_o=0, score_o=0, running_q=0.
- Because running_q resets to 0, a low running_i right after reset produces no stop event.
- dp_o, hit_o, miss_o: one-cycle latency from inputs.
- Score update becomes visible one cycle after hit_o goes high.
- guess_valid_o: zero latency, combinational.
- Reset asserted mid-operation immediately clears all registers, including a pending pulse.
- Back-to-back stop events need at least one cycle of running_i=1 between them. Each stop event yields exactly one pulse.
- score_clr_i and hit_o in the same cycle: clear wins, score becomes 0.

## Configuration
- GUESS_EVAL_SCORE_EN:
  - Defined: 4-bit score counter and score_clr_i logic are compiled in, as described above.
  - Undefined: no counter. score_o is tied to 4'd0 and score_clr_i is ignored.
  - The port list is identical in both cases.
  - dp_o, hit_o, miss_o and guess_valid_o are unaffected by the macro.

## Test plan
- guess_i=6'b010000, running_i=1, sweep pos_i 0..5 -> dp_o stays 0, no pulses.
- guess_i=6'b010000, running_i=0, sweep pos_i 0..7 at 1 position/cycle -> dp_o=1 exactly one cycle after pos_i=4, 0 otherwise (6, 7 included).
- running_i 1->0 with pos_i=4, guess bit4 -> single hit_o pulse, score_o 0->1 (macro on) or stays 0 (macro off). Repeat with pos_i=2 -> single miss_o pulse, score unchanged.
- guess_i=6'b010010 or 6'b000000 -> guess_valid_o=0, dp_o=0, stop event gives miss_o.
- 16 hit stop events -> score_o saturates at 15. score_clr_i during a hit cycle -> score_o=0.
- Assert rst_ni low in the cycle after a stop event -> hit_o/miss_o, dp_o, score_o read 0 immediately, with no pulse after release while running_i=0.
